// File: rtl/onp_rpn_if.sv
// Character handshake bundle for onp_rpn: strobe/ack input side and
// strobe/ack output side.
interface onp_rpn_if;
    logic       in_stb;
    logic [7:0] in_char;
    logic       in_ack;
    logic       out_stb;
    logic [7:0] out_char;
    logic       out_ack;

    modport slave (
        input  in_stb,
        input  in_char,
        output in_ack,
        output out_stb,
        output out_char,
        input  out_ack
    );

    modport master (
        output in_stb,
        output in_char,
        input  in_ack,
        input  out_stb,
        input  out_char,
        output out_ack
    );
endinterface

// File: rtl/onp_rpn.sv
// onp_rpn: streaming infix-to-RPN converter (shunting-yard).
// One input char at a time in, one RPN char per cycle out.
module onp_rpn #(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    onp_rpn_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    localparam logic [7:0] C_SPC = 8'h20;
    localparam logic [7:0] C_LP  = 8'h28;
    localparam logic [7:0] C_RP  = 8'h29;
    localparam logic [7:0] C_EQ  = 8'h3D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEP,
        ST_POP,
        ST_POP_SP,
        ST_EMIT,
        ST_FLUSH,
        ST_PUSH,
        ST_SKIP,
        ST_CONT
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) ||
               (c == 8'h2A) || (c == 8'h2F);
    endfunction

    function automatic logic prec(input logic [7:0] c);
        return (c == 8'h2A) || (c == 8'h2F);
    endfunction

    function automatic logic is_known(input logic [7:0] c);
        return is_digit(c) || is_op(c) || (c == C_LP) ||
               (c == C_RP) || (c == C_EQ);
    endfunction

    state_t        st_q, st_d;
    logic [7:0]    ch_q, ch_d;
    logic          num_q, num_d;
    logic          out_stb_q, out_stb_d;
    logic [7:0]    out_char_q, out_char_d;
    logic [SW-1:0] sp_q, sp_d;
    logic [7:0]    stk_q [DEPTH];
    logic [7:0]    stk_d [DEPTH];

    logic [SW-1:0] spm1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [7:0]    top;
    logic          has_top;
    logic          full;
    logic          hs;
    logic [7:0]    rch;

    state_t        r_st;
    logic          r_stb;
    logic [7:0]    r_chr;
    logic          r_pop;
    logic          r_done;
    logic          use_r;

    assign spm1     = sp_q - SW'(1);
    assign top_idx  = spm1[AW-1:0];
    assign push_idx = sp_q[AW-1:0];
    assign top      = stk_q[top_idx];
    assign has_top  = (sp_q != '0);
    assign full     = (sp_q == SW'(DEPTH));
    assign hs       = out_stb_q && bus.out_ack;
    assign rch      = (st_q == ST_IDLE) ? bus.in_char : ch_q;

    assign bus.in_ack   = (st_q == ST_IDLE);
    assign bus.out_stb  = out_stb_q;
    assign bus.out_char = out_char_q;

    // Next step for an operator/paren/'=' once any separator is out.
    always_comb begin
        r_st   = ST_IDLE;
        r_stb  = 1'b0;
        r_chr  = 8'h00;
        r_pop  = 1'b0;
        r_done = 1'b0;
        unique case (1'b1)
            is_op(rch): begin
                if (has_top && (top != C_LP) &&
                    (prec(top) >= prec(rch))) begin
                    r_pop = 1'b1;
                    r_stb = 1'b1;
                    r_chr = top;
                    r_st  = ST_POP;
                end else begin
                    r_st = ST_PUSH;
                end
            end
            (rch == C_LP): begin
                r_st = ST_PUSH;
            end
            (rch == C_RP): begin
                r_pop = has_top;
                if (has_top && (top != C_LP)) begin
                    r_stb = 1'b1;
                    r_chr = top;
                    r_st  = ST_POP;
                end else begin
                    r_done = 1'b1;
                end
            end
            (rch == C_EQ): begin
                r_pop = has_top;
                if (!has_top) begin
                    r_stb = 1'b1;
                    r_chr = C_EQ;
                    r_st  = ST_FLUSH;
                end else if (top != C_LP) begin
                    r_stb = 1'b1;
                    r_chr = top;
                    r_st  = ST_POP;
                end else begin
                    r_st = ST_CONT;
                end
            end
            default: begin
                r_done = 1'b1;
            end
        endcase
    end

    always_comb begin
        st_d       = st_q;
        ch_d       = ch_q;
        num_d      = num_q;
        out_stb_d  = out_stb_q;
        out_char_d = out_char_q;
        sp_d       = sp_q;
        stk_d      = stk_q;
        use_r      = 1'b0;

        unique case (st_q)
            ST_IDLE: begin
                if (bus.in_stb) begin
                    ch_d = bus.in_char;
                    if (is_digit(bus.in_char)) begin
                        out_stb_d  = 1'b1;
                        out_char_d = bus.in_char;
                        num_d      = 1'b1;
                        st_d       = ST_EMIT;
                    end else if (!is_known(bus.in_char)) begin
                        st_d = ST_SKIP;
                    end else if (num_q) begin
                        out_stb_d  = 1'b1;
                        out_char_d = C_SPC;
                        num_d      = 1'b0;
                        st_d       = ST_SEP;
                    end else begin
                        use_r = 1'b1;
                    end
                end
            end
            ST_SEP, ST_POP_SP: begin
                use_r = hs;
            end
            ST_POP: begin
                if (hs) begin
                    out_char_d = C_SPC;
                    st_d       = ST_POP_SP;
                end
            end
            ST_EMIT, ST_FLUSH: begin
                if (hs) begin
                    out_stb_d = 1'b0;
                    st_d      = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (!full) begin
                    stk_d[push_idx] = ch_q;
                    sp_d            = sp_q + SW'(1);
                end
                st_d = ST_IDLE;
            end
            ST_SKIP: begin
                st_d = ST_IDLE;
            end
            ST_CONT: begin
                use_r = 1'b1;
            end
            default: begin
                out_stb_d = 1'b0;
                st_d      = ST_IDLE;
            end
        endcase

        // A transfer must always drop in_ack for at least one cycle.
        if (use_r) begin
            out_stb_d = r_stb;
            if (r_stb) begin
                out_char_d = r_chr;
            end
            if (r_pop) begin
                sp_d = spm1;
            end
            if (r_done) begin
                st_d = (st_q == ST_IDLE) ? ST_SKIP : ST_IDLE;
            end else begin
                st_d = r_st;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= ST_IDLE;
            ch_q       <= 8'h00;
            num_q      <= 1'b0;
            out_stb_q  <= 1'b0;
            out_char_q <= 8'h00;
            sp_q       <= '0;
            stk_q      <= '{default: 8'h00};
        end else begin
            st_q       <= st_d;
            ch_q       <= ch_d;
            num_q      <= num_d;
            out_stb_q  <= out_stb_d;
            out_char_q <= out_char_d;
            sp_q       <= sp_d;
            stk_q      <= stk_d;
        end
    end
endmodule

// File: tb/tb_onp_rpn.sv
// Bench for onp_rpn: queue-based shunting-yard model, per-cycle
// output checks, directed literals and random expressions.
module tb_onp_rpn;
    localparam int DEPTH = 16;
    typedef logic [7:0] ch_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    onp_rpn_if bus();

    onp_rpn #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    ch_t exp_q[$];
    ch_t got_q[$];
    ch_t mexp_q[$];
    ch_t mstk[$];
    bit  mnum;
    int  ack_mode = 0;
    bit  noise_en = 0;
    bit  hold_v, xfer_v, xfer_imm;
    ch_t hold_c;

    function automatic bit m_digit(ch_t c);
        return c inside {[8'h30:8'h39]};
    endfunction

    function automatic bit m_op(ch_t c);
        return c inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
    endfunction

    function automatic int m_prec(ch_t c);
        return (c == 8'h2A || c == 8'h2F) ? 2 : 1;
    endfunction

    function automatic bit m_known(ch_t c);
        return m_digit(c) || m_op(c) || c inside {8'h28, 8'h29, 8'h3D};
    endfunction

    function automatic void emit(ch_t c);
        exp_q.push_back(c);
        mexp_q.push_back(c);
    endfunction

    function automatic void m_clear();
        exp_q.delete();
        mstk.delete();
        mnum = 0;
        hold_v = 0;
        xfer_v = 0;
    endfunction

    // Reference shunting-yard on whole characters.
    function automatic void mfeed(ch_t c);
        ch_t t;
        if (m_digit(c)) begin
            emit(c);
            mnum = 1;
        end else if (m_known(c)) begin
            if (mnum) begin
                emit(8'h20);
                mnum = 0;
            end
            if (m_op(c)) begin
                while (mstk.size() > 0 && mstk[$] != 8'h28 &&
                       m_prec(mstk[$]) >= m_prec(c)) begin
                    emit(mstk.pop_back());
                    emit(8'h20);
                end
                if (mstk.size() < DEPTH) mstk.push_back(c);
            end else if (c == 8'h28) begin
                if (mstk.size() < DEPTH) mstk.push_back(c);
            end else if (c == 8'h29) begin
                while (mstk.size() > 0 && mstk[$] != 8'h28) begin
                    emit(mstk.pop_back());
                    emit(8'h20);
                end
                if (mstk.size() > 0) t = mstk.pop_back();
            end else begin
                while (mstk.size() > 0) begin
                    t = mstk.pop_back();
                    if (t != 8'h28) begin
                        emit(t);
                        emit(8'h20);
                    end
                end
                emit(8'h3D);
            end
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    task automatic cmp_str(string nm, ch_t q[$], string s);
        bit ok;
        string a, b;
        ok = (q.size() == s.len());
        for (int i = 0; ok && i < s.len(); i++)
            if (q[i] !== ch_t'(s[i])) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            a = "";
            b = "";
            for (int i = 0; i < q.size() && i < 40; i++)
                a = {a, $sformatf("%02h ", q[i])};
            for (int i = 0; i < s.len() && i < 40; i++)
                b = {b, $sformatf("%02h ", s[i])};
            $display("FAIL %s: got [%s] want [%s]", nm, a, b);
        end
    endtask

    // Output acknowledge driver.
    initial begin
        bus.out_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0: bus.out_ack = 1'b1;
                1: bus.out_ack = ($urandom_range(0, 99) < 60);
                default: bus.out_ack = 1'b0;
            endcase
        end
    end

    // Per-cycle compare process.
    always @(negedge clk) begin
        if (reset) begin
            if (xfer_v) begin
                chk("ack_drop", bus.in_ack, 0);
                if (xfer_imm) chk("first_out", bus.out_stb, 1);
                xfer_v = 0;
            end
            if (hold_v) begin
                chk("hold_stb", bus.out_stb, 1);
                chk("hold_char", bus.out_char, hold_c);
                hold_v = 0;
            end
            if (bus.out_stb) chk("busy_ack", bus.in_ack, 0);
            if (bus.out_stb && bus.out_ack) begin
                got_q.push_back(bus.out_char);
                if (exp_q.size() == 0)
                    chk("extra_out", bus.out_char, 0);
                else
                    chk("out_char", bus.out_char, exp_q.pop_front());
            end else if (bus.out_stb) begin
                hold_v = 1;
                hold_c = bus.out_char;
            end
            if (bus.in_stb && bus.in_ack) begin
                xfer_v = 1;
                xfer_imm = m_digit(bus.in_char) ||
                           (mnum && m_known(bus.in_char));
                mfeed(bus.in_char);
            end
        end
    end

    task automatic send(ch_t c);
        int n = 0;
        while (!bus.in_ack && n < 500) begin
            if (noise_en) begin
                bus.in_stb  = 1'($urandom_range(0, 1));
                bus.in_char = 8'($urandom_range(0, 255));
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ack) begin
            chk("send_timeout", 0, 1);
            bus.in_stb = 1'b0;
        end else begin
            bus.in_stb  = 1'b1;
            bus.in_char = c;
            @(posedge clk);
            #1;
            bus.in_stb = 1'b0;
        end
    endtask

    task automatic run_expr(string s);
        for (int i = 0; i < s.len(); i++) send(ch_t'(s[i]));
    endtask

    task automatic drain();
        int n = 0;
        while (!(bus.in_ack && !bus.out_stb && exp_q.size() == 0) &&
               n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4000) chk("drain_timeout", 0, 1);
    endtask

    task automatic dir(string nm, string si, string so);
        got_q.delete();
        mexp_q.delete();
        run_expr(si);
        drain();
        cmp_str({nm, " dut"}, got_q, so);
        cmp_str({nm, " model"}, mexp_q, so);
    endtask

    string din[5] = '{"2+1+1=", "3+4*2=", "(3+4)*2=", "12-5=", "1 )+2="};
    string dout[5] = '{"2 1 + 1 + =", "3 4 2 * + =", "3 4 + 2 * =",
                       "12 5 - =", "1 2 + ="};
    string pool = "0123456789+-*/()()= x";

    initial begin
        bus.in_stb  = 1'b0;
        bus.in_char = 8'h00;
        m_clear();

        #12;
        chk("rst_out_stb", bus.out_stb, 0);
        chk("rst_out_char", bus.out_char, 8'h00);
        chk("rst_in_ack", bus.in_ack, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_in_ack", bus.in_ack, 1);

        for (int i = 0; i < 5; i++) dir(din[i], din[i], dout[i]);

        // Backpressure while the first digit is pending.
        got_q.delete();
        mexp_q.delete();
        ack_mode = 2;
        bus.out_ack = 1'b0;
        send(8'h32);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_out_stb", bus.out_stb, 1);
        chk("bp_out_char", bus.out_char, 8'h32);
        chk("bp_in_ack", bus.in_ack, 0);
        ack_mode = 0;
        bus.out_ack = 1'b1;
        run_expr("+1=");
        drain();
        cmp_str("backpressure", got_q, "2 1 + =");

        dir("overflow", "(((((((((((((((((1=", "1 =");
        dir("after_overflow", "2+3=", "2 3 + =");

        // Reset in the middle of an expression.
        run_expr("12*(3");
        drain();
        ack_mode = 2;
        bus.out_ack = 1'b0;
        send(8'h2B);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        m_clear();
        #1;
        chk("midrst_out_stb", bus.out_stb, 0);
        chk("midrst_out_char", bus.out_char, 8'h00);
        chk("midrst_in_ack", bus.in_ack, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ack_mode = 0;
        bus.out_ack = 1'b1;
        @(posedge clk);
        #1;
        dir("after_reset", "3+4*2=", "3 4 2 * + =");

        // Random expressions under random backpressure and noise.
        noise_en = 1;
        ack_mode = 1;
        for (int e = 0; e < 60; e++) begin
            int len;
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++)
                send(ch_t'(pool[$urandom_range(0, pool.len() - 1)]));
            send(8'h3D);
        end
        noise_en = 0;
        bus.in_stb = 1'b0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
